// File: rtl/uart_rx_port.sv
// UART receive port: 8N1 deserialiser feeding a small byte FIFO read by the CPU.
// Each stored byte raises an int_sig pulse; overrun and frame errors are sticky until err_clr.
module uart_rx_port #(
  parameter int CLKS_PER_BIT     = 16,
  parameter int FIFO_DEPTH       = 4,
  parameter int INT_PULSE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        load_uart,
  input  logic        uart_read_end,
  input  logic        err_clr,
  output logic [31:0] rd_data,
  output logic        rx_valid,
  output logic        int_sig,
  output logic        overrun,
  output logic        frame_err,
  output logic [1:0]  dbg_state_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(INT_PULSE_CYCLES + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_s_q, rx_prev_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            push_q, push_d;
  logic [7:0]      push_byte_q, push_byte_d;
  logic            ferr_set;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic [IW-1:0]   int_cnt_q;
  logic            overrun_q, frame_err_q;
  logic            full, pop, push_ok;

  // The CPU read strobe carries no side effect here; the head is always presented.
  logic            load_unused;
  assign load_unused = load_uart;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      push_byte_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      push_byte_q <= push_byte_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    push_byte_d = push_byte_q;
    ferr_set    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s_q) begin
          state_d = START;
          bit_d   = '0;
        end
      end
      START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s_q) begin
            push_d      = 1'b1;
            push_byte_d = shift_q;
          end else begin
            ferr_set = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop     = uart_read_end && (count_q != '0);
  // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
  assign push_ok = push_q && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_byte_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      int_cnt_q   <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (!push_ok && pop) count_q <= count_q - (AW+1)'(1);
      if (push_ok)               int_cnt_q <= IW'(INT_PULSE_CYCLES);
      else if (int_cnt_q != '0)  int_cnt_q <= int_cnt_q - IW'(1);
      if (push_q && !push_ok) overrun_q <= 1'b1;
      else if (err_clr)       overrun_q <= 1'b0;
      if (ferr_set)           frame_err_q <= 1'b1;
      else if (err_clr)       frame_err_q <= 1'b0;
    end
  end

  assign rx_valid    = (count_q != '0);
  assign rd_data     = rx_valid ? {24'b0, mem_q[rd_ptr_q]} : 32'b0;
  assign int_sig     = (int_cnt_q != '0);
  assign overrun     = overrun_q;
  assign frame_err   = frame_err_q;
  assign dbg_state_o = state_q;

endmodule
